fast_corner_scanner: RTL and testbench
======================================

# fast_corner_scanner

Parametrised FAST-N corner scan engine, the successor to the single-pixel feature-detector top. It walks every interior pixel of an image held in single-port SRAM and fetches each reference pixel plus its 16 Bresenham-circle neighbours. It classifies each neighbour against a run-time threshold and streams out corner addresses over a valid/ready handshake. Arc length, image size and pixel width are parameters, and the threshold is a port.

## Interface
- IMG_W, 256: image width in pixels (≥7)
- IMG_H, 128: image height in pixels (≥7)
- ADDR_W, 15: SRAM address width; IMG_W*IMG_H ≤ 2^ADDR_W
- PIX_W, 8: pixel width
- ARC_LEN, 9: contiguous circle pixels required (1..16)
- CNT_W, 16: corner counter width
- clock  in  1  rising-edge clock
- nReset  in  1  asynchronous active-low reset
- start  in  1  begin a scan; sampled only in IDLE
- thres  in  PIX_W  threshold; latched when start is accepted
- sramAddr  out  ADDR_W  SRAM read address
- sramRden  out  1  read strobe
- sramData  in  PIX_W  SRAM q; valid the cycle after sramRden
- cornerValid  out  1  corner address available
- cornerReady  in  1  consumer accepts
- cornerAddr  out  ADDR_W  linear address of the corner pixel
- cornerCount  out  CNT_W  corners emitted this scan; saturates at all-ones
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse on scan completion

## Operation
- Scan order is raster over y=3..IMG_H-4 (outer loop) and x=3..IMG_W-4 (inner loop). refAddr = y*IMG_W+x.
- Fetch index k=0 reads the reference pixel. Indices k=1..16 read circle point i=k-1 at refAddr + dy*IMG_W + dx.
- Circle points i=0..15 in (dx,dy) order: (0,-3) (1,-3) (2,-2) (3,-1) (3,0) (3,1) (2,2) (1,3) (0,3) (-1,3) (-2,2) (-3,1) (-3,0) (-3,-1) (-2,-2) (-1,-3).
- Classification of each circle point uses PIX_W+1-bit unsigned arithmetic with no wrap:
  - bright[i] = p[i] > ref + thres
  - dark[i] = p[i] + thres < ref
  - Equality is neither.
- The pixel is a corner if some ARC_LEN circularly contiguous indices are all bright, or all dark. Runs wrap from i=15 to i=0. Mixed bright/dark runs never qualify.
- States:
  - IDLE: waits for start. Accepting start clears cornerCount, latches thres and loads the first refAddr.
  - FETCH: 17 cycles, k=0..16, with sramRden=1 and sramAddr per k.
  - CAPTURE: 1 cycle that registers the k=16 data.
  - EVAL: 1 cycle that computes the corner decision. Corner goes to EMIT. Non-corner goes to FETCH of the next pixel, or to IDLE after the last pixel.
  - EMIT: cornerValid=1. On cornerValid&&cornerReady, cornerCount increments and the engine advances like a non-corner EVAL.
- In EMIT, cornerAddr and cornerValid stay stable until the handshake; backpressure stalls the scan. cornerValid is 0 in all other states.
- start while busy is ignored; thres changes after acceptance have no effect.
- An IMG_W=IMG_H=7 image has exactly one candidate pixel, at address 24.

## Timing
- Reset values: sramAddr=0, sramRden=0, cornerValid=0, cornerAddr=0, cornerCount=0, busy=0, done=0, state IDLE.
- Asserting nReset mid-scan returns immediately to IDLE, drops cornerValid, and issues no done.
- start is accepted at edge 0. FETCH k=0 runs in cycle 1 and busy rises in cycle 1.
- sramData for a read issued in cycle c is captured at the end of cycle c+1.
- Each non-corner pixel takes exactly 19 cycles: 17 FETCH, 1 CAPTURE, 1 EVAL. Each corner pixel takes 19 + 1 + W cycles, where W is the number of cycles cornerReady is held low in EMIT.
- A corner's cornerValid rises the cycle after its EVAL.
- done pulses in the first IDLE cycle after the last pixel, with busy=0 in that cycle. A start in that same cycle is accepted.
- cornerCount holds its final value until the next accepted start.

## Test plan
- 7x7 image, all pixels 100, thres=10, start → no cornerValid; done 20 cycles after the start edge; cornerCount=0.
- 7x7 image, ref=100, circle i=0..8 set to 120, rest 100, thres=10 → cornerValid with cornerAddr=24; cornerReady=1 gives count 1 and done 21 cycles after start.
- Wrap case: ref=100, i=12..15 and 0..4 set to 80, thres=10 → corner detected, cornerAddr=24.
- Negative cases:
  - Only i=0..7 set to 120 → no corner.
  - All circle points 110 with thres=10 (the equality boundary) → no corner.
  - ref=250, circle=255, thres=10 → no corner, because the sum is not truncated.
- Backpressure: scenario 2 with cornerReady low for 5 cycles → cornerValid and cornerAddr stable for 6 cycles; done 26 cycles after start.
- 16x16 random image with golden-model comparison, plus:
  - nReset pulsed mid-FETCH → all outputs return to reset values, and a following scan matches the model exactly.
  - start pulsed while busy → ignored.

Source files
------------

// File: rtl/fast_corner_scanner.sv
// fast_corner_scanner
// Walks every interior pixel of an image held in single-port SRAM. For each
// pixel it reads the reference value and the 16 points of the radius-3
// Bresenham circle, then classifies each circle point as bright or dark
// against a latched threshold. A pixel is a corner when ARC_LEN circularly
// contiguous points are all bright, or all dark. Corner addresses leave on a
// valid/ready stream.
//
// Stream handshake: cornerValid is raised only in EMIT. While it is high,
// cornerAddr is held stable. A transfer happens on a rising clock edge where
// cornerValid && cornerReady. cornerValid never depends combinationally on
// cornerReady.
module fast_corner_scanner #(
  parameter int IMG_W   = 256,
  parameter int IMG_H   = 128,
  parameter int ADDR_W  = 15,
  parameter int PIX_W   = 8,
  parameter int ARC_LEN = 9,
  parameter int CNT_W   = 16
) (
  input  logic              clock,
  input  logic              nReset,
  input  logic              start,
  input  logic [PIX_W-1:0]  thres,
  output logic [ADDR_W-1:0] sramAddr,
  output logic              sramRden,
  input  logic [PIX_W-1:0]  sramData,
  output logic              cornerValid,
  input  logic              cornerReady,
  output logic [ADDR_W-1:0] cornerAddr,
  output logic [CNT_W-1:0]  cornerCount,
  output logic              busy,
  output logic              done,
  output logic [2:0]        stateDbg
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    CAPTURE = 3'd2,
    EVAL    = 3'd3,
    EMIT    = 3'd4
  } state_t;

  localparam int XW        = $clog2(IMG_W);
  localparam int YW        = $clog2(IMG_H);
  localparam int FIRST_REF = 3 * IMG_W + 3;
  localparam int X_LAST    = IMG_W - 4;
  localparam int Y_LAST    = IMG_H - 4;
  // Stepping from the last column of a row to column 3 of the next row.
  localparam int ROW_STEP  = 7;

  state_t            state;
  logic [XW-1:0]     xPos;
  logic [YW-1:0]     yPos;
  logic [ADDR_W-1:0] refAddr;
  logic [4:0]        kIdx;
  logic [PIX_W-1:0]  thresLat;
  // pixReg[0] is the reference pixel, pixReg[i+1] is circle point i.
  logic [PIX_W-1:0]  pixReg [0:16];

  logic [15:0]       bright;
  logic [15:0]       dark;
  logic              isCorner;
  logic [PIX_W:0]    refSum;
  logic [PIX_W:0]    pExt;
  logic              runB;
  logic              runD;

  logic              lastPix;
  logic              rowEnd;
  logic              advance;
  logic [ADDR_W-1:0] nextRef;

  assign stateDbg = state;

  // Address offset of fetch index k relative to the reference pixel.
  function automatic logic [ADDR_W-1:0] fetchOffset(input logic [4:0] k);
    int dx;
    int dy;
    dx = 0;
    dy = 0;
    case (k)
      5'd1:    begin dx =  0; dy = -3; end
      5'd2:    begin dx =  1; dy = -3; end
      5'd3:    begin dx =  2; dy = -2; end
      5'd4:    begin dx =  3; dy = -1; end
      5'd5:    begin dx =  3; dy =  0; end
      5'd6:    begin dx =  3; dy =  1; end
      5'd7:    begin dx =  2; dy =  2; end
      5'd8:    begin dx =  1; dy =  3; end
      5'd9:    begin dx =  0; dy =  3; end
      5'd10:   begin dx = -1; dy =  3; end
      5'd11:   begin dx = -2; dy =  2; end
      5'd12:   begin dx = -3; dy =  1; end
      5'd13:   begin dx = -3; dy =  0; end
      5'd14:   begin dx = -3; dy = -1; end
      5'd15:   begin dx = -2; dy = -2; end
      5'd16:   begin dx = -1; dy = -3; end
      default: begin dx =  0; dy =  0; end
    endcase
    return ADDR_W'(dy * IMG_W + dx);
  endfunction

  // Bright/dark classification in PIX_W+1 bits so ref+thres never wraps,
  // followed by a search for a contiguous run with wrap-around.
  always_comb begin
    bright   = '0;
    dark     = '0;
    isCorner = 1'b0;
    pExt     = '0;
    runB     = 1'b0;
    runD     = 1'b0;
    refSum   = {1'b0, pixReg[0]} + {1'b0, thresLat};
    for (int i = 0; i < 16; i++) begin
      pExt           = {1'b0, pixReg[5'(i + 1)]};
      bright[4'(i)]  = pExt > refSum;
      dark[4'(i)]    = (pExt + {1'b0, thresLat}) < {1'b0, pixReg[0]};
    end
    for (int s = 0; s < 16; s++) begin
      runB = 1'b1;
      runD = 1'b1;
      for (int j = 0; j < ARC_LEN; j++) begin
        runB = runB & bright[4'((s + j) % 16)];
        runD = runD & dark[4'((s + j) % 16)];
      end
      if (runB || runD) isCorner = 1'b1;
    end
  end

  // Raster position bookkeeping for moving to the next candidate pixel.
  always_comb begin
    rowEnd  = (xPos == XW'(X_LAST));
    lastPix = rowEnd && (yPos == YW'(Y_LAST));
    nextRef = rowEnd ? (refAddr + ADDR_W'(ROW_STEP)) : (refAddr + ADDR_W'(1));
    advance = ((state == EVAL) && !isCorner) ||
              ((state == EMIT) && cornerReady);
  end

  // Scan controller: fetch sequencing, capture, evaluation and emission.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state       <= IDLE;
      xPos        <= '0;
      yPos        <= '0;
      refAddr     <= '0;
      kIdx        <= '0;
      thresLat    <= '0;
      sramAddr    <= '0;
      sramRden    <= 1'b0;
      cornerValid <= 1'b0;
      cornerAddr  <= '0;
      cornerCount <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      for (int i = 0; i < 17; i++) pixReg[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state       <= FETCH;
            busy        <= 1'b1;
            thresLat    <= thres;
            cornerCount <= '0;
            refAddr     <= ADDR_W'(FIRST_REF);
            xPos        <= XW'(3);
            yPos        <= YW'(3);
            kIdx        <= '0;
            sramAddr    <= ADDR_W'(FIRST_REF);
            sramRden    <= 1'b1;
          end
        end
        FETCH: begin
          // Data for the read issued last cycle is on sramData now.
          if (kIdx != 5'd0) pixReg[kIdx - 5'd1] <= sramData;
          if (kIdx == 5'd16) begin
            state    <= CAPTURE;
            sramRden <= 1'b0;
          end else begin
            kIdx     <= kIdx + 5'd1;
            sramAddr <= refAddr + fetchOffset(kIdx + 5'd1);
          end
        end
        CAPTURE: begin
          pixReg[16] <= sramData;
          state      <= EVAL;
        end
        EVAL: begin
          if (isCorner) begin
            state       <= EMIT;
            cornerValid <= 1'b1;
            cornerAddr  <= refAddr;
          end
        end
        EMIT: begin
          if (cornerReady) begin
            cornerValid <= 1'b0;
            if (cornerCount != '1) cornerCount <= cornerCount + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase

      // Move on to the next pixel, or finish after the last one.
      if (advance) begin
        if (lastPix) begin
          state    <= IDLE;
          busy     <= 1'b0;
          done     <= 1'b1;
        end else begin
          state    <= FETCH;
          kIdx     <= '0;
          refAddr  <= nextRef;
          sramAddr <= nextRef;
          sramRden <= 1'b1;
          if (rowEnd) begin
            xPos <= XW'(3);
            yPos <= yPos + YW'(1);
          end else begin
            xPos <= xPos + XW'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_fast_corner_scanner.sv
// tb_fast_corner_scanner
// Directed 7x7 cases with hand-computed results, plus a 16x16 image scanned
// against a golden corner model with random backpressure.
module tb_fast_corner_scanner;

  // ---------------- clock / reset ----------------
  logic clock;
  logic nReset;
  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic        start7, start16, cornerReady;
  logic [7:0]  thres;

  logic [14:0] sramAddr7, cornerAddr7, sramAddr16, cornerAddr16;
  logic        sramRden7, sramRden16, cornerValid7, cornerValid16;
  logic [7:0]  sramData7, sramData16;
  logic [15:0] cornerCount7, cornerCount16;
  logic        busy7, busy16, done7, done16;
  logic [2:0]  state7, state16;

  fast_corner_scanner #(.IMG_W(7), .IMG_H(7), .ADDR_W(15), .PIX_W(8),
                        .ARC_LEN(9), .CNT_W(16)) dut7 (
    .clock(clock), .nReset(nReset), .start(start7), .thres(thres),
    .sramAddr(sramAddr7), .sramRden(sramRden7), .sramData(sramData7),
    .cornerValid(cornerValid7), .cornerReady(cornerReady),
    .cornerAddr(cornerAddr7), .cornerCount(cornerCount7),
    .busy(busy7), .done(done7), .stateDbg(state7)
  );

  fast_corner_scanner #(.IMG_W(16), .IMG_H(16), .ADDR_W(15), .PIX_W(8),
                        .ARC_LEN(9), .CNT_W(16)) dut16 (
    .clock(clock), .nReset(nReset), .start(start16), .thres(thres),
    .sramAddr(sramAddr16), .sramRden(sramRden16), .sramData(sramData16),
    .cornerValid(cornerValid16), .cornerReady(cornerReady),
    .cornerAddr(cornerAddr16), .cornerCount(cornerCount16),
    .busy(busy16), .done(done16), .stateDbg(state16)
  );

  // ---------------- SRAM models (one-cycle read latency) ----------------
  logic [7:0] mem7  [0:48];
  logic [7:0] mem16 [0:255];

  always @(posedge clock) begin
    if (sramRden7)  sramData7  <= mem7[sramAddr7];
    if (sramRden16) sramData16 <= mem16[sramAddr16];
  end

  int cdx [16] = '{0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3, -3, -3, -2, -1};
  int cdy [16] = '{-3, -3, -2, -1, 0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3};

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [14:0] exp_q[$];
  int expN;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Golden corner model for the 16x16 image (ARC_LEN 9, integer arithmetic).
  function automatic bit modelCorner(input int ra, input logic [7:0] th);
    bit b [16];
    bit d [16];
    int r, p, t;
    bit ab, ad, hit;
    r = int'(mem16[ra]);
    t = int'(th);
    hit = 1'b0;
    for (int i = 0; i < 16; i++) begin
      p = int'(mem16[ra + cdy[i] * 16 + cdx[i]]);
      b[i] = (p > r + t);
      d[i] = (p + t < r);
    end
    for (int s = 0; s < 16; s++) begin
      ab = 1'b1;
      ad = 1'b1;
      for (int j = 0; j < 9; j++) begin
        ab = ab & b[(s + j) % 16];
        ad = ad & d[(s + j) % 16];
      end
      if (ab || ad) hit = 1'b1;
    end
    return hit;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic load7(input logic [7:0] refV, input logic [7:0] setV,
                       input logic [7:0] otherV, input logic [15:0] mask);
    for (int a = 0; a < 49; a++) mem7[a] = 8'd100;
    mem7[24] = refV;
    for (int i = 0; i < 16; i++) mem7[24 + cdy[i] * 7 + cdx[i]] = mask[i] ? setV : otherV;
  endtask

  // Runs one 7x7 scan; cornerReady is held low for waitCyc EMIT cycles.
  // Cycle 1 is the cycle right after the edge that accepts start.
  task automatic scen7(input string tag, input int waitCyc, input int expDone,
                       input bit expCorner, input int expValid);
    logic [7:0]  t;
    logic [14:0] seenAddr;
    int cyc, doneCyc, validCyc, accepted;
    bit stable, busyAt1;
    t = thres;
    doneCyc = 0; validCyc = 0; accepted = 0; stable = 1'b1; seenAddr = '0;
    cornerReady = (waitCyc == 0);
    start7 = 1'b1;
    @(posedge clock); #1;
    start7 = 1'b0;
    thres = ~t;  // must have no effect after acceptance
    cyc = 1;
    busyAt1 = busy7;
    while (cyc < 300) begin
      if (done7) begin
        doneCyc = cyc;
        break;
      end
      if (cornerValid7) begin
        validCyc++;
        if (validCyc == 1) seenAddr = cornerAddr7;
        else if (cornerAddr7 !== seenAddr) stable = 1'b0;
        cornerReady = (validCyc > waitCyc);
        if (cornerReady) accepted++;
      end
      @(posedge clock); #1;
      cyc++;
    end
    check({tag, "_busy_c1"}, busyAt1, 1);
    check({tag, "_done_cycle"}, doneCyc, expDone);
    check({tag, "_busy_at_done"}, busy7, 0);
    check({tag, "_valid_cycles"}, validCyc, expValid);
    check({tag, "_count"}, cornerCount7, expCorner ? 1 : 0);
    check({tag, "_accepted"}, accepted, expCorner ? 1 : 0);
    if (expCorner) begin
      check({tag, "_addr"}, seenAddr, 24);
      check({tag, "_stable"}, stable, 1);
    end
    @(posedge clock); #1;
    check({tag, "_done_pulse"}, done7, 0);
    check({tag, "_count_hold"}, cornerCount7, expCorner ? 1 : 0);
    thres = t;
    cornerReady = 1'b1;
  endtask

  task automatic fill16;
    for (int a = 0; a < 256; a++) mem16[a] = 8'($urandom_range(90, 110));
    repeat (8) mem16[$urandom_range(0, 255)] = 8'd230;
    repeat (4) mem16[$urandom_range(0, 255)] = 8'd10;
  endtask

  task automatic expect16;
    exp_q.delete();
    for (int y = 3; y <= 12; y++)
      for (int x = 3; x <= 12; x++)
        if (modelCorner(y * 16 + x, thres)) exp_q.push_back(15'(y * 16 + x));
    expN = exp_q.size();
  endtask

  // Full 16x16 scan with random backpressure; optionally pokes start mid-scan.
  task automatic run16(input string tag, input bit pokeStart);
    logic [7:0] t;
    int cyc, got;
    t = thres;
    got = 0;
    start16 = 1'b1;
    @(posedge clock); #1;
    start16 = 1'b0;
    thres = ~t;
    cyc = 1;
    while (cyc < 8000) begin
      if (done16) break;
      if (pokeStart) start16 = (cyc == 40);
      cornerReady = ($urandom_range(0, 3) != 0);
      if (cornerValid16 && cornerReady) begin
        got++;
        if (exp_q.size() > 0) check({tag, "_sb_addr"}, cornerAddr16, exp_q.pop_front());
      end
      @(posedge clock); #1;
      cyc++;
    end
    start16 = 1'b0;
    check({tag, "_done"}, done16, 1);
    check({tag, "_corners"}, got, expN);
    check({tag, "_count"}, cornerCount16, expN);
    check({tag, "_sb_left"}, exp_q.size(), 0);
    @(posedge clock); #1;
    check({tag, "_idle_after"}, busy16, 0);
    thres = t;
    cornerReady = 1'b1;
  endtask

  task automatic checkReset16(input string tag);
    check({tag, "_sramAddr"}, sramAddr16, 0);
    check({tag, "_sramRden"}, sramRden16, 0);
    check({tag, "_valid"}, cornerValid16, 0);
    check({tag, "_caddr"}, cornerAddr16, 0);
    check({tag, "_count"}, cornerCount16, 0);
    check({tag, "_busy"}, busy16, 0);
    check({tag, "_done"}, done16, 0);
    check({tag, "_state"}, state16, 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    nReset = 1'b0;
    start7 = 1'b0;
    start16 = 1'b0;
    thres = 8'd10;
    cornerReady = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("rst7_valid", cornerValid7, 0);
    check("rst7_busy", busy7, 0);
    check("rst7_sramRden", sramRden7, 0);
    check("rst7_count", cornerCount7, 0);
    checkReset16("rst16");
    nReset = 1'b1;
    @(posedge clock); #1;

    // Flat image: no corner, 19-cycle pixel.
    load7(8'd100, 8'd100, 8'd100, 16'h0000);
    scen7("flat", 0, 20, 1'b0, 0);
    // Nine bright points i=0..8.
    load7(8'd100, 8'd120, 8'd100, 16'h01FF);
    scen7("bright9", 0, 21, 1'b1, 1);
    // Nine dark points wrapping i=12..15,0..4.
    load7(8'd100, 8'd80, 8'd100, 16'hF01F);
    scen7("dark_wrap", 0, 21, 1'b1, 1);
    // Only eight bright points.
    load7(8'd100, 8'd120, 8'd100, 16'h00FF);
    scen7("bright8", 0, 20, 1'b0, 0);
    // Equality boundary: p == ref + thres.
    load7(8'd100, 8'd110, 8'd110, 16'hFFFF);
    scen7("equal", 0, 20, 1'b0, 0);
    // ref + thres = 260 must not truncate.
    load7(8'd250, 8'd255, 8'd255, 16'hFFFF);
    scen7("no_trunc", 0, 20, 1'b0, 0);
    // Mixed run: five bright then four dark.
    load7(8'd100, 8'd120, 8'd80, 16'h001F);
    for (int i = 9; i < 16; i++) mem7[24 + cdy[i] * 7 + cdx[i]] = 8'd100;
    scen7("mixed", 0, 20, 1'b0, 0);
    // Backpressure: five cycles of cornerReady low.
    load7(8'd100, 8'd120, 8'd100, 16'h01FF);
    scen7("backpress", 5, 26, 1'b1, 6);

    // 16x16 golden-model scans.
    thres = 8'd20;
    fill16();
    expect16();
    run16("scan_a", 1'b0);

    // Reset mid-FETCH, then a clean scan.
    start16 = 1'b1;
    @(posedge clock); #1;
    start16 = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    check("mid_busy", busy16, 1);
    nReset = 1'b0;
    #1;
    checkReset16("midrst");
    #2;
    nReset = 1'b1;
    @(posedge clock); #1;
    check("midrst_no_done", done16, 0);

    fill16();
    expect16();
    run16("scan_b", 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
